forwarding_unit: RTL and testbench

//  RV32-style EX-stage data-forwarding selector for a 5-stage in-order pipeline.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/fwd_sel_one.sv | 34 +++
 rtl/forwarding_unit.sv | 72 +++++++
 tb/tb_forwarding_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: register index and operand-forwarding select encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int REG_AW = 5;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // Operand source for the EX-stage ALU; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_EX  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/fwd_sel_one.sv
// Match and priority logic selecting the forwarding source for one ALU operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the output follows the inputs continuously.
module fwd_sel_one
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [REG_AW-1:0] rs,
    output fwd_sel_e          sel
);

    logic ex_hit;
    logic mem_hit;

    // x0 is hard-wired zero, so a write to rd == 0 must never be forwarded.
    assign ex_hit  = ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    assign mem_hit = mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);

    // EX/MEM holds the younger result, so it wins over MEM/WB when both match.
    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage forwarding selector for rs1/rs2 plus saturating forwarding-event counters.
// Latency: selects are combinational (zero cycles); counters update on each clk edge.
// Backpressure: none; selects are always valid, counters saturate instead of wrapping.
module forwarding_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_mem_regwrite,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              mem_wb_regwrite,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [REG_AW-1:0] id_ex_rs1,
    input  logic [REG_AW-1:0] id_ex_rs2,
    output logic [1:0]        forwardA,
    output logic [1:0]        forwardB,
    output logic [CNT_W-1:0]  fwd_ex_cnt,
    output logic [CNT_W-1:0]  fwd_mem_cnt
);

    fwd_sel_e sel_a;
    fwd_sel_e sel_b;
    logic     any_ex;
    logic     any_mem;

    fwd_sel_one #(.REG_AW(REG_AW)) u_sel_rs1 (
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .rs              (id_ex_rs1),
        .sel             (sel_a)
    );

    fwd_sel_one #(.REG_AW(REG_AW)) u_sel_rs2 (
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .rs              (id_ex_rs2),
        .sel             (sel_b)
    );

    assign forwardA = sel_a;
    assign forwardB = sel_b;

    // A cycle counts once per stage even when both operands use that stage.
    assign any_ex  = (sel_a == FWD_EX)  || (sel_b == FWD_EX);
    assign any_mem = (sel_a == FWD_MEM) || (sel_b == FWD_MEM);

    // Count cycles forwarding from EX/MEM, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_ex_cnt <= '0;
        end else if (any_ex && (fwd_ex_cnt != '1)) begin
            fwd_ex_cnt <= fwd_ex_cnt + 1'b1;
        end
    end

    // Count cycles forwarding from MEM/WB, holding at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_mem_cnt <= '0;
        end else if (any_mem && (fwd_mem_cnt != '1)) begin
            fwd_mem_cnt <= fwd_mem_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit: select encoding/priority and counter behaviour.
// Latency: selects sampled 1 time unit after input changes; counters 1 unit after posedge.
// Backpressure: n/a.
module tb_forwarding_unit;

    logic       clk;
    logic       rst_n;
    logic       ex_mem_regwrite;
    logic [4:0] ex_mem_rd;
    logic       mem_wb_regwrite;
    logic [4:0] mem_wb_rd;
    logic [4:0] id_ex_rs1;
    logic [4:0] id_ex_rs2;
    logic [1:0] forwardA;
    logic [1:0] forwardB;
    logic [15:0] fwd_ex_cnt;
    logic [15:0] fwd_mem_cnt;
    logic [1:0] forwardA_s;
    logic [1:0] forwardB_s;
    logic [1:0] fwd_ex_cnt_s;
    logic [1:0] fwd_mem_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    forwarding_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .forwardA        (forwardA),
        .forwardB        (forwardB),
        .fwd_ex_cnt      (fwd_ex_cnt),
        .fwd_mem_cnt     (fwd_mem_cnt)
    );

    // Narrow-counter instance to reach saturation in a few cycles.
    forwarding_unit #(.REG_AW(5), .CNT_W(2)) dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_mem_regwrite (ex_mem_regwrite),
        .ex_mem_rd       (ex_mem_rd),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .id_ex_rs1       (id_ex_rs1),
        .id_ex_rs2       (id_ex_rs2),
        .forwardA        (forwardA_s),
        .forwardB        (forwardB_s),
        .fwd_ex_cnt      (fwd_ex_cnt_s),
        .fwd_mem_cnt     (fwd_mem_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic exw, input logic [4:0] exrd,
                         input logic mww, input logic [4:0] mwrd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        ex_mem_regwrite = exw;
        ex_mem_rd       = exrd;
        mem_wb_regwrite = mww;
        mem_wb_rd       = mwrd;
        id_ex_rs1       = rs1;
        id_ex_rs2       = rs2;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd1, 5'd2);

        // Reset state and selects valid while reset is held.
        check("rst_ex_cnt",  fwd_ex_cnt, 16'd0);
        check("rst_mem_cnt", fwd_mem_cnt, 16'd0);
        check("idle_A", {14'd0, forwardA}, 16'h0);
        check("idle_B", {14'd0, forwardB}, 16'h0);

        drive(1'b1, 5'd1, 1'b0, 5'd0, 5'd1, 5'd3);
        check("ex_rs1_A", {14'd0, forwardA}, 16'h2);
        check("ex_rs1_B", {14'd0, forwardB}, 16'h0);

        drive(1'b1, 5'd3, 1'b0, 5'd0, 5'd4, 5'd3);
        check("ex_rs2_A", {14'd0, forwardA}, 16'h0);
        check("ex_rs2_B", {14'd0, forwardB}, 16'h2);

        drive(1'b0, 5'd3, 1'b1, 5'd4, 5'd4, 5'd5);
        check("mem_rs1_A", {14'd0, forwardA}, 16'h1);
        check("mem_rs1_B", {14'd0, forwardB}, 16'h0);

        drive(1'b1, 5'd6, 1'b1, 5'd6, 5'd6, 5'd6);
        check("prio_both_A", {14'd0, forwardA}, 16'h2);
        check("prio_both_B", {14'd0, forwardB}, 16'h2);

        drive(1'b1, 5'd6, 1'b1, 5'd9, 5'd6, 5'd9);
        check("mixed_A", {14'd0, forwardA}, 16'h2);
        check("mixed_B", {14'd0, forwardB}, 16'h1);

        drive(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        check("x0_A", {14'd0, forwardA}, 16'h0);
        check("x0_B", {14'd0, forwardB}, 16'h0);

        drive(1'b0, 5'd7, 1'b0, 5'd8, 5'd7, 5'd8);
        check("masked_A", {14'd0, forwardA}, 16'h0);
        check("masked_B", {14'd0, forwardB}, 16'h0);

        drive(1'b1, 5'd10, 1'b1, 5'd11, 5'd11, 5'd10);
        check("cross_A", {14'd0, forwardA}, 16'h1);
        check("cross_B", {14'd0, forwardB}, 16'h2);

        // Counters must not move while reset is held, despite matches.
        repeat (3) @(posedge clk);
        #1;
        check("hold_rst_ex",  fwd_ex_cnt, 16'd0);
        check("hold_rst_mem", fwd_mem_cnt, 16'd0);

        // EX match on rs1 only for 5 edges.
        @(negedge clk);
        drive(1'b1, 5'd1, 1'b0, 5'd0, 5'd1, 5'd3);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("cnt5_ex",        fwd_ex_cnt, 16'd5);
        check("cnt5_mem",       fwd_mem_cnt, 16'd0);
        check("cnt5_small_ex",  {14'd0, fwd_ex_cnt_s}, 16'd3);
        check("cnt5_small_mem", {14'd0, fwd_mem_cnt_s}, 16'd0);

        // rs1 from EX/MEM and rs2 from MEM/WB: both counters advance.
        @(negedge clk);
        drive(1'b1, 5'd1, 1'b1, 5'd5, 5'd1, 5'd5);
        repeat (2) @(posedge clk);
        #1;
        check("both2_ex",        fwd_ex_cnt, 16'd7);
        check("both2_mem",       fwd_mem_cnt, 16'd2);
        check("both2_small_mem", {14'd0, fwd_mem_cnt_s}, 16'd2);
        repeat (3) @(posedge clk);
        #1;
        check("both5_ex",        fwd_ex_cnt, 16'd10);
        check("both5_mem",       fwd_mem_cnt, 16'd5);
        check("sat_small_ex",    {14'd0, fwd_ex_cnt_s}, 16'd3);
        check("sat_small_mem",   {14'd0, fwd_mem_cnt_s}, 16'd3);

        // Both operands from EX/MEM in one cycle count once.
        @(negedge clk);
        drive(1'b1, 5'd2, 1'b0, 5'd0, 5'd2, 5'd2);
        @(posedge clk);
        #1;
        check("dual_ex_once", fwd_ex_cnt, 16'd11);
        check("dual_ex_mem",  fwd_mem_cnt, 16'd5);

        // Asynchronous reset between edges clears immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ex",       fwd_ex_cnt, 16'd0);
        check("async_rst_mem",      fwd_mem_cnt, 16'd0);
        check("async_rst_small_ex", {14'd0, fwd_ex_cnt_s}, 16'd0);

        // x0 writes never count.
        @(negedge clk);
        drive(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("x0_cnt_ex",  fwd_ex_cnt, 16'd0);
        check("x0_cnt_mem", fwd_mem_cnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
